rom_arbiter: RTL

//  Shares one synchronous single-port ROM (1-cycle read latency, Do=0 when EN low) between two

---
 rtl/rom_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter that shares one 1-cycle-latency ROM between two read ports.
// Each port has a one-deep registered response buffer with valid/ready back-pressure.
module rom_arbiter #(
  parameter  int unsigned MEM_WORDS = 8192,
  localparam int unsigned ADR_WIDTH = $clog2(MEM_WORDS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic [ADR_WIDTH-1:0] ADDR0,
  output logic                 GNT0,
  output logic                 RVALID0,
  output logic [31:0]          RDATA0,
  input  logic                 RREADY0,
  input  logic                 REQ1,
  input  logic [ADR_WIDTH-1:0] ADDR1,
  output logic                 GNT1,
  output logic                 RVALID1,
  output logic [31:0]          RDATA1,
  input  logic                 RREADY1,
  output logic                 ROM_EN,
  output logic [ADR_WIDTH-1:0] ROM_A,
  input  logic [31:0]          ROM_DO
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NPORTS = 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q [NPORTS];
  state_e              state_d [NPORTS];
  logic [DATA_W-1:0]   rdata_q [NPORTS];
  logic [DATA_W-1:0]   rdata_d [NPORTS];
  logic [NPORTS-1:0]   rvalid_q, rvalid_d;
  logic                last_q, last_d;
  logic [NPORTS-1:0]   req, rready, elig, gnt;

  assign req    = {REQ1, REQ0};
  assign rready = {RREADY1, RREADY0};

  // State register; last_q=1 makes port0 win the first tie after reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NPORTS; i++) begin
        state_q[i] <= S_IDLE;
        rdata_q[i] <= '0;
      end
      rvalid_q <= '0;
      last_q   <= 1'b1;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        state_q[i] <= state_d[i];
        rdata_q[i] <= rdata_d[i];
      end
      rvalid_q <= rvalid_d;
      last_q   <= last_d;
    end
  end

  // Arbitration and ROM-side outputs
  always_comb begin
    elig = '0;
    gnt  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      elig[i] = req[i] && ((state_q[i] == S_IDLE) ||
                           ((state_q[i] == S_RESP) && rready[i]));
    end
    if (!RST) begin
      if (elig == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else               gnt = elig;
    end
    GNT0   = gnt[0];
    GNT1   = gnt[1];
    ROM_EN = |gnt;
    ROM_A  = gnt[0] ? ADDR0 : (gnt[1] ? ADDR1 : {ADR_WIDTH{1'b0}});
  end

  // Per-port next state; the response buffer captures ROM_DO on the WAIT cycle
  always_comb begin
    last_d   = last_q;
    rvalid_d = '0;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;
    for (int i = 0; i < NPORTS; i++) begin
      state_d[i] = state_q[i];
      rdata_d[i] = rdata_q[i];
      case (state_q[i])
        S_IDLE: if (gnt[i]) state_d[i] = S_WAIT;
        S_WAIT: begin
          state_d[i] = S_RESP;
          rdata_d[i] = ROM_DO;
        end
        S_RESP: if (rready[i]) state_d[i] = gnt[i] ? S_WAIT : S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
      rvalid_d[i] = (state_d[i] == S_RESP);
    end
  end

  assign RVALID0 = rvalid_q[0];
  assign RVALID1 = rvalid_q[1];
  assign RDATA0  = rdata_q[0];
  assign RDATA1  = rdata_q[1];

endmodule
